fc_writeback: RTL and testbench
===============================

# fc_writeback

Writeback engine for the fully-connected stage. When an FC layer reports completion, this block snapshots that layer's output-node vector and streams it, one 16-bit word per cycle, into the shared feature memory at a programmable base address, under a ready/valid write handshake. It sits between an `fc_layer` instance and the shared memory port, mirroring the memory-to-layer load path in the opposite direction. An optional argmax tracker reports the winning class index for the final layer.

## Interface
- `NUM_NODES`, default 84, number of output nodes written per transfer (≥2)
- `DATA_W`, default 16, node and memory word width
- `ADDR_W`, default 14, memory address width
- `IDX_W`, default `$clog2(NUM_NODES)`, node index width

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first destination address; sampled with `start`
- `nodes_in`  in  NUM_NODES*DATA_W  layer outputs; node k occupies bits [k*DATA_W +: DATA_W]; sampled with `start`
- `mem_we`  out  1  write valid
- `mem_ready`  in  1  memory accepts the write this cycle
- `mem_addr`  out  ADDR_W  write address
- `mem_data`  out  DATA_W  write data
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse after the last write is accepted
- `max_idx`  out  IDX_W  argmax index (see Configuration)
- `max_val`  out  DATA_W  argmax value (see Configuration)

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `mem_we`=0. On `start`=1, latch `nodes_in` into an internal snapshot, latch `base_addr`, clear index to 0, and go to WRITE. After capture, `nodes_in` may change freely.
- WRITE: `mem_we`=1, `mem_addr` = base + idx (mod 2^ADDR_W, wrap allowed), `mem_data` = snapshot[idx]. A beat transfers on `mem_we && mem_ready`. When a beat transfers with idx < NUM_NODES-1, idx increments. When the beat with idx = NUM_NODES-1 transfers, go to DONE. While `mem_ready`=0, address and data are held stable.
- DONE: `mem_we`=0, `done`=1 for exactly this cycle, then return to IDLE.
- `start` is ignored in WRITE and DONE. It is not queued.
- Every node is written exactly once, in ascending index order. No duplicate beats.

## Timing
- On reset (`reset`=0 at a clock edge), the block enters IDLE and sets `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `max_idx`=0, `max_val`=0, and idx=0.
- Reset during WRITE aborts the transfer immediately. No further writes occur and no `done` pulse is issued.
- `start` is asserted at edge 0. The first `mem_we` appears in cycle 1.
- With `mem_ready` held at 1, the last write occurs in cycle NUM_NODES and `done` pulses in cycle NUM_NODES+1. Each stall cycle adds one cycle to this latency.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `start` asserted in the same cycle as `done` is ignored. A new transfer can be accepted at the earliest in the first IDLE cycle.

## Configuration
- `FC_ARGMAX_EN` defined:
  - On each transferred beat, compare the beat value as a signed (two's-complement) number.
  - Idx 0 always loads the tracker.
  - A later beat replaces the held max only if strictly greater, so ties keep the lowest index.
  - `max_idx`/`max_val` are updated registers, final and valid when `done`=1, and held until the next accepted `start`.
- `FC_ARGMAX_EN` undefined: the tracker logic is not built and `max_idx`/`max_val` are tied to 0. All other behaviour is identical.

## Test plan
- NUM_NODES=84, base_addr=10204, nodes k=k+1, mem_ready=1 → 84 writes to addr 10204..10287 with data 1..84, `done` pulse in cycle 85, `busy` high in cycles 1..85.
- Same transfer with mem_ready low on every odd cycle → data and address held during each stall, each address written exactly once, `done` delayed by the number of stall cycles.
- base_addr=16380, NUM_NODES=10 → addresses 16380..16383, then 0..5 (wrap-around).
- Reset asserted during beat 40 → `mem_we`=0 next cycle, no `done`, all outputs at reset values. A fresh start then completes normally.
- A `start` pulse during WRITE, and another coincident with `done` → both ignored, exactly one transfer observed.
- `FC_ARGMAX_EN`, NUM_NODES=10, values {-5,3,7,7,-1,0,2,7,-8,1} → `max_idx`=2, `max_val`=7 at `done`. All values -3 → `max_idx`=0. Without the macro → both outputs stay 0.

Source files
------------

// File: rtl/fc_writeback_if.sv
// Write-port bundle between the FC writeback engine and the shared feature memory.
// The engine drives the master side; the memory drives mem_ready.
interface fc_writeback_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_data,
        output mem_ready
    );
endinterface

// File: rtl/fc_writeback.sv
// FC writeback engine: snapshots a layer's node vector on start and streams it to memory.
// Optional argmax tracker is built only when FC_ARGMAX_EN is defined.
module fc_writeback #(
    parameter int NUM_NODES = 84,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 14,
    parameter int IDX_W     = $clog2(NUM_NODES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [NUM_NODES*DATA_W-1:0] nodes_in,
    fc_writeback_if.master              wr,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            max_idx,
    output logic [DATA_W-1:0]           max_val
);
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   node_word [NUM_NODES];
    logic [DATA_W-1:0]   snap_reg  [NUM_NODES];
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_inc;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                capture;
    logic                beat;
    logic                last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NODES; gi++) begin : g_snap
            assign node_word[gi] = nodes_in[gi*DATA_W +: DATA_W];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    snap_reg[gi] <= '0;
                end else if (capture) begin
                    snap_reg[gi] <= node_word[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        wr.mem_we  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr.mem_we = 1'b1;
                beat      = wr.mem_ready;
                last_beat = beat && (idx_reg == LAST_IDX);
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign idx_inc = idx_reg + 1'b1;

    // Address and data are registered and only advance on an accepted beat,
    // so they stay stable across stalls; word 0 comes straight from nodes_in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg  <= '0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (capture) begin
            idx_reg  <= '0;
            addr_reg <= base_addr;
            data_reg <= node_word[0];
        end else if (beat && !last_beat) begin
            idx_reg  <= idx_inc;
            addr_reg <= addr_reg + 1'b1;
            data_reg <= snap_reg[idx_inc];
        end
    end

    assign wr.mem_addr = addr_reg;
    assign wr.mem_data = data_reg;

`ifdef FC_ARGMAX_EN
    logic [IDX_W-1:0]  max_idx_reg;
    logic [DATA_W-1:0] max_val_reg;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_idx_reg <= '0;
            max_val_reg <= '0;
        end else if (beat && ((idx_reg == '0) || ($signed(data_reg) > $signed(max_val_reg)))) begin
            max_idx_reg <= idx_reg;
            max_val_reg <= data_reg;
        end
    end

    assign max_idx = max_idx_reg;
    assign max_val = max_val_reg;
`else
    assign max_idx = '0;
    assign max_val = '0;
`endif

endmodule

// File: tb/tb_fc_writeback.sv
// Scoreboard bench for fc_writeback: driver pushes expected beats per transfer,
// an independent monitor pops and compares every accepted write and done pulse.
module tb_fc_writeback;
    localparam int N  = 84;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [N*DW-1:0] nodes_in = '0;
    logic            busy;
    logic            done;
    logic [IW-1:0]   max_idx;
    logic [DW-1:0]   max_val;

    fc_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

    fc_writeback #(
        .NUM_NODES(N),
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .nodes_in(nodes_in),
        .wr(wr_if),
        .busy(busy),
        .done(done),
        .max_idx(max_idx),
        .max_val(max_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    logic [IW-1:0] exp_midx_q [$];
    logic [DW-1:0] exp_mval_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory-side ready pattern: 0 always ready, 1 low on odd cycles, 2 random.
    int ready_mode = 0;
    int cyc = 0;
    initial begin
        wr_if.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                1:       wr_if.mem_ready = (cyc % 2 == 0);
                2:       wr_if.mem_ready = ($urandom_range(0, 3) != 0);
                default: wr_if.mem_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && wr_if.mem_we) begin
                    check("stall_addr_hold", 32'(wr_if.mem_addr), 32'(prev_addr));
                    check("stall_data_hold", 32'(wr_if.mem_data), 32'(prev_data));
                end
                if (wr_if.mem_we && wr_if.mem_ready) begin
                    check("beat_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                    if (exp_addr_q.size() > 0) begin
                        check("beat_addr", 32'(wr_if.mem_addr), 32'(exp_addr_q.pop_front()));
                        check("beat_data", 32'(wr_if.mem_data), 32'(exp_data_q.pop_front()));
                    end
                end
                if (done) begin
                    check("done_expected", 32'(exp_midx_q.size() > 0), 32'd1);
                    if (exp_midx_q.size() > 0) begin
                        check("done_all_beats_written", 32'(exp_addr_q.size()), 32'd0);
                        check("max_idx", 32'(max_idx), 32'(exp_midx_q.pop_front()));
                        check("max_val", 32'(max_val), 32'(exp_mval_q.pop_front()));
                    end
                end
                prev_stall = wr_if.mem_we && !wr_if.mem_ready;
                prev_addr  = wr_if.mem_addr;
                prev_data  = wr_if.mem_data;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},   32'(wr_if.mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(wr_if.mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(wr_if.mem_data), 32'd0);
        check({tag, "_busy"},     32'(busy),           32'd0);
        check({tag, "_done"},     32'(done),           32'd0);
        check({tag, "_max_idx"},  32'(max_idx),        32'd0);
        check({tag, "_max_val"},  32'(max_val),        32'd0);
    endtask

    // pattern: 0 k+1, 1 random, 2 argmax vector, 3 all -3
    // extra:   0 none, 1 spurious starts, 2 reset during beat 40
    task automatic run_transfer(input logic [AW-1:0] base, input int pattern,
                                input int mode, input int extra);
        logic [DW-1:0] vals [N];
        logic [DW-1:0] argv [10];
        int best;
        int c;
        int stalls;
        int beats;
        int bad;
        logic got_done;
        argv = '{16'hFFFB, 16'd3, 16'd7, 16'd7, 16'hFFFF, 16'd0, 16'd2, 16'd7, 16'hFFF8, 16'd1};
        for (int k = 0; k < N; k++) begin
            case (pattern)
                0:       vals[k] = DW'(k + 1);
                2:       vals[k] = (k < 10) ? argv[k] : 16'hFFF7;
                3:       vals[k] = 16'hFFFD;
                default: vals[k] = DW'($urandom);
            endcase
        end
        best = 0;
        for (int k = 1; k < N; k++) begin
            if ($signed(vals[k]) > $signed(vals[best])) best = k;
        end
        ready_mode = mode;

        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        for (int k = 0; k < N; k++) begin
            nodes_in[k*DW +: DW] = vals[k];
            exp_addr_q.push_back(AW'(base + AW'(k)));
            exp_data_q.push_back(vals[k]);
        end
`ifdef FC_ARGMAX_EN
        exp_midx_q.push_back(IW'(best));
        exp_mval_q.push_back(vals[best]);
`else
        exp_midx_q.push_back('0);
        exp_mval_q.push_back('0);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) nodes_in[k*DW +: DW] = DW'($urandom);

        c = 1;
        stalls = 0;
        beats = 0;
        got_done = 1'b0;
        while (c <= 4000 && !got_done) begin
            @(negedge clk);
            check("busy_high", 32'(busy), 32'd1);
            if (wr_if.mem_we && !wr_if.mem_ready) stalls++;
            if (wr_if.mem_we && wr_if.mem_ready) beats++;
            if (done) begin
                got_done = 1'b1;
                check("done_latency", 32'(c), 32'(N + 1 + stalls));
                check("beat_count", 32'(beats), 32'(N));
            end else begin
                @(posedge clk);
                #1;
                start = 1'b0;
                if (extra == 1 && c == 5) begin
                    start     = 1'b1;
                    base_addr = '0;
                end
                if (extra == 1 && mode == 0 && c == N) begin
                    start     = 1'b1;
                    base_addr = AW'(100);
                end
                if (extra == 2 && beats == 40) begin
                    reset = 1'b0;
                    @(posedge clk);
                    #1;
                    reset = 1'b1;
                    exp_addr_q.delete();
                    exp_data_q.delete();
                    exp_midx_q.delete();
                    exp_mval_q.delete();
                    @(negedge clk);
                    check_reset_outputs("abort");
                    bad = 0;
                    repeat (100) begin
                        @(negedge clk);
                        if (wr_if.mem_we || done || busy) bad++;
                    end
                    check("abort_quiet_cycles", 32'(bad), 32'd0);
                    $display("transfer base=%0d pattern=%0d mode=%0d aborted after %0d beats", base, pattern, mode, beats);
                    return;
                end
                c++;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("idle_no_write", 32'(wr_if.mem_we), 32'd0);
        if (extra == 1) begin
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (wr_if.mem_we || busy || done) bad++;
            end
            check("spurious_start_ignored", 32'(bad), 32'd0);
        end
        $display("transfer base=%0d pattern=%0d mode=%0d cycles=%0d stalls=%0d max_idx=%0d max_val=%0d",
                 base, pattern, mode, c, stalls, max_idx, max_val);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_transfer(AW'(10204), 0, 0, 0);
        run_transfer(AW'(10204), 0, 1, 0);
        run_transfer(AW'(16380), 1, 2, 0);
        run_transfer(AW'(500),   1, 0, 2);
        run_transfer(AW'(2000),  1, 0, 0);
        run_transfer(AW'(3000),  1, 0, 1);
        run_transfer(AW'(40),    2, 2, 0);
        run_transfer(AW'(77),    3, 1, 0);
        for (int t = 0; t < 4; t++) begin
            run_transfer(AW'($urandom), 1, int'($urandom_range(0, 2)), 0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_addr_q.size() + exp_midx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
